// File: rtl/march_sequencer_pkg.sv
// rtl/march_sequencer_pkg.sv - shared types and March C- element table for the sequencer
package march_sequencer_pkg;

  localparam int ADDR_WIDTH = 8;

  localparam logic ADMD_LIUD = 1'b0;
  localparam logic ADMD_PRUD = 1'b1;

  localparam int NUM_ELEMS = 6;
  localparam int ELEM_W    = 3;
  localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(NUM_ELEMS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_OP,
    ST_FIN
  } state_e;

  // One bit per element, indexed by element number (bits 7:6 unused).
  localparam logic [7:0] ELEM_DOWN    = 8'b0001_1000;
  localparam logic [7:0] ELEM_TWO_OPS = 8'b0001_1110;
  localparam logic [7:0] OP0_READ     = 8'b0011_1110;
  localparam logic [7:0] OP0_DATA     = 8'b0001_0100;
  localparam logic [7:0] OP1_DATA     = 8'b0000_1010;

  typedef struct packed {
    logic is_read;
    logic data;
    logic is_last;
    logic dir;
  } rom_entry_t;

endpackage

// File: rtl/march_rom.sv
// rtl/march_rom.sv - combinational (element, op) lookup for the March C- algorithm
module march_rom
  import march_sequencer_pkg::*;
(
  input  logic [ELEM_W-1:0] elem_i,
  input  logic              op_i,
  output rom_entry_t        entry_o
);

  always_comb begin
    entry_o         = '0;
    entry_o.dir     = ELEM_DOWN[elem_i];
    entry_o.is_last = op_i | ~ELEM_TWO_OPS[elem_i];
    if (!op_i) begin
      entry_o.is_read = OP0_READ[elem_i];
      entry_o.data    = OP0_DATA[elem_i];
    end else begin
      // The second op of every two-op element is a write.
      entry_o.is_read = 1'b0;
      entry_o.data    = OP1_DATA[elem_i];
    end
  end

endmodule

// File: rtl/march_sequencer.sv
// rtl/march_sequencer.sv - March C- control FSM driving address_counter and memory strobes
module march_sequencer
  import march_sequencer_pkg::*;
#(
  parameter int tasw = ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic              admd_in,
  output logic              s_out,
  output logic              r_out,
  output logic              hold_out,
  output logic              updwn_out,
  output logic              we_out,
  output logic              re_out,
  output logic              wd_out,
  output logic              exp_out,
  output logic [ELEM_W-1:0] elem_out,
  output logic              busy_out,
  output logic              done_out
);

  // Last visit index: LIUD walks all 2^tasw addresses, PRUD skips the LFSR zero state.
  localparam logic [tasw:0] LAST_LIUD = {1'b0, {tasw{1'b1}}};
  localparam logic [tasw:0] LAST_PRUD = LAST_LIUD - {{tasw{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ELEM_W-1:0]   elem_q, elem_d;
  logic                op_q, op_d;
  logic [tasw:0]       visit_q, visit_d;
  logic [tasw:0]       visit_last;
  rom_entry_t          rom;

  march_rom u_rom (
    .elem_i  (elem_q),
    .op_i    (op_q),
    .entry_o (rom)
  );

  assign visit_last = (admd_in == ADMD_PRUD) ? LAST_PRUD : LAST_LIUD;
  assign elem_out   = elem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      elem_q  <= '0;
      op_q    <= 1'b0;
      visit_q <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      op_q    <= op_d;
      visit_q <= visit_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    op_d      = op_q;
    visit_d   = visit_q;
    s_out     = 1'b0;
    r_out     = 1'b0;
    hold_out  = 1'b1;
    updwn_out = 1'b0;
    we_out    = 1'b0;
    re_out    = 1'b0;
    wd_out    = 1'b0;
    exp_out   = 1'b0;
    busy_out  = 1'b0;
    done_out  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d = ST_INIT;
          elem_d  = '0;
          op_d    = 1'b0;
          visit_d = '0;
        end
      end

      ST_INIT: begin
        busy_out  = 1'b1;
        updwn_out = rom.dir;
        s_out     = ~rom.dir;
        r_out     = rom.dir;
        state_d   = ST_OP;
      end

      ST_OP: begin
        busy_out  = 1'b1;
        updwn_out = rom.dir;
        re_out    = rom.is_read;
        we_out    = ~rom.is_read;
        exp_out   = rom.is_read & rom.data;
        wd_out    = ~rom.is_read & rom.data;
        // The counter only steps on the last op of each address visit.
        hold_out  = ~rom.is_last;
        if (!rom.is_last) begin
          op_d = op_q + 1'b1;
        end else if (visit_q != visit_last) begin
          op_d    = 1'b0;
          visit_d = visit_q + 1'b1;
        end else if (elem_q != LAST_ELEM) begin
          elem_d  = elem_q + 1'b1;
          op_d    = 1'b0;
          visit_d = '0;
          state_d = ST_INIT;
        end else begin
          state_d = ST_FIN;
        end
      end

      ST_FIN: begin
        done_out = 1'b1;
        elem_d   = '0;
        op_d     = 1'b0;
        visit_d  = '0;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_march_sequencer.sv
// tb/tb_march_sequencer.sv - randomized self-checking bench for march_sequencer
module tb_march_sequencer;

  localparam int TASW = 8;

  logic       clk = 1'b0;
  logic       rst, start_in, admd_in;
  logic       s_out, r_out, hold_out, updwn_out, we_out, re_out, wd_out, exp_out;
  logic       busy_out, done_out;
  logic [2:0] elem_out;

  int checks = 0;
  int errors = 0;

  march_sequencer #(.tasw(TASW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_in  (start_in),
    .admd_in   (admd_in),
    .s_out     (s_out),
    .r_out     (r_out),
    .hold_out  (hold_out),
    .updwn_out (updwn_out),
    .we_out    (we_out),
    .re_out    (re_out),
    .wd_out    (wd_out),
    .exp_out   (exp_out),
    .elem_out  (elem_out),
    .busy_out  (busy_out),
    .done_out  (done_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // March C-: M0 up(w0) M1 up(r0,w1) M2 up(r1,w0) M3 down(r0,w1) M4 down(r1,w0) M5 up(r0)
  int nops [6]    = '{1, 2, 2, 2, 2, 1};
  bit down [6]    = '{0, 0, 0, 1, 1, 0};
  bit rd   [6][2] = '{'{0, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}};
  bit dat  [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};

  typedef struct {
    logic [10:0] v;
    logic        we;
    logic        re;
    logic        d;
  } exp_t;

  exp_t q[$];

  function automatic logic [10:0] vec(input bit s, input bit r, input bit h, input bit u,
                                      input bit we, input bit re, input bit busy,
                                      input bit done, input int e);
    return {s, r, h, u, we, re, busy, done, 3'(e)};
  endfunction

  function automatic logic [10:0] obs();
    return {s_out, r_out, hold_out, updwn_out, we_out, re_out, busy_out, done_out, elem_out};
  endfunction

  logic [10:0] idle_v;
  assign idle_v = vec(0, 0, 1, 0, 0, 0, 0, 0, 0);

  function automatic int visits(input bit admd);
    return admd ? (1 << TASW) - 1 : (1 << TASW);
  endfunction

  task automatic build(input bit admd);
    exp_t e;
    int   n;
    bit   last;
    n = visits(admd);
    q.delete();
    for (int el = 0; el < 6; el++) begin
      e.v = vec(!down[el], down[el], 1, down[el], 0, 0, 1, 0, el);
      e.we = 0; e.re = 0; e.d = 0;
      q.push_back(e);
      for (int v = 0; v < n; v++) begin
        for (int o = 0; o < nops[el]; o++) begin
          last = (o == nops[el] - 1);
          e.v  = vec(0, 0, !last, down[el], !rd[el][o], rd[el][o], 1, 0, el);
          e.we = !rd[el][o];
          e.re = rd[el][o];
          e.d  = dat[el][o];
          q.push_back(e);
        end
      end
    end
    e.v = vec(0, 0, 1, 0, 0, 0, 0, 1, 5);
    e.we = 0; e.re = 0; e.d = 0;
    q.push_back(e);
  endtask

  task automatic run_one(input bit admd, input bit held, input int abort_at);
    int   n, busy_cnt, done_at;
    exp_t e;
    n = visits(admd);
    admd_in = admd;
    build(admd);
    busy_cnt = 0;
    done_at  = -1;
    @(negedge clk);
    check("idle_pre", obs(), idle_v);
    start_in = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      if (!held) start_in = (i < q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      e = q[i];
      check($sformatf("seq[%0d]", i), obs(), e.v);
      if (e.we) check($sformatf("wd[%0d]", i), wd_out, e.d);
      if (e.re) check($sformatf("exp[%0d]", i), exp_out, e.d);
      busy_cnt += int'(busy_out);
      if (done_out && done_at < 0) done_at = i + 1;
      if (i == abort_at) begin
        rst      = 1'b1;
        start_in = 1'b0;
        @(negedge clk);
        check("rst_idle", obs(), idle_v);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("post_rst_idle", obs(), idle_v);
        end
        return;
      end
    end
    check("busy_cycles", busy_cnt, 6 + 10 * n);
    check("done_cycle", done_at, 7 + 10 * n);
    @(negedge clk);
    check("idle_post", obs(), idle_v);
    if (held) begin
      @(negedge clk);
      check("rerun_init", obs(), vec(1, 0, 1, 0, 0, 0, 1, 0, 0));
      start_in = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      check("rerun_abort", obs(), idle_v);
      rst = 1'b0;
    end
  endtask

  initial begin
    bit a;
    int n;
    rst      = 1'b1;
    start_in = 1'b0;
    admd_in  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("reset", obs(), idle_v);
    end
    rst = 1'b0;

    run_one(1'b0, 1'b0, -1);
    run_one(1'b1, 1'b0, -1);

    a = 1'($urandom_range(0, 1));
    n = visits(a);
    run_one(a, 1'b0, 3 * n + 3 + int'($urandom_range(0, 2 * n - 1)));
    run_one(a, 1'b0, -1);

    run_one(1'($urandom_range(0, 1)), 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
